// File: rtl/mult_pkg.sv
// ----------------------------------------------------------------------------
// mult_pkg
// Shared helpers for the mult_pipe multiplier family.
//   full_w()   : width of the full product of an A_W x B_W multiply.
//   sat_smax() : largest two's complement value representable in out_w bits.
//   sat_smin() : smallest two's complement value representable in out_w bits.
//   sat_umax() : largest unsigned value representable in out_w bits.
// The limit helpers return LIM_W-bit vectors; callers slice them down to the
// width they compare at, so one set of helpers serves every parametrisation.
// ----------------------------------------------------------------------------
package mult_pkg;

    localparam int LIM_W = 128;

    function automatic int full_w(input int a_w, input int b_w);
        return a_w + b_w;
    endfunction

    function automatic logic [LIM_W-1:0] sat_umax(input int out_w);
        logic [LIM_W-1:0] r;
        r = '0;
        for (int i = 0; i < LIM_W; i++) begin
            if (i < out_w) r[i] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [LIM_W-1:0] sat_smax(input int out_w);
        logic [LIM_W-1:0] r;
        r = '0;
        for (int i = 0; i < LIM_W; i++) begin
            if (i < out_w - 1) r[i] = 1'b1;
        end
        return r;
    endfunction

    // Bitwise complement of 2^(w-1)-1 is -2^(w-1) in two's complement.
    function automatic logic [LIM_W-1:0] sat_smin(input int out_w);
        return ~sat_smax(out_w);
    endfunction

endpackage

// File: rtl/mult_round_sat.sv
// ----------------------------------------------------------------------------
// mult_round_sat
// Combinational output scaling for mult_pipe: round-half-up right shift of the
// full product, then fit check and clamp to OUT_W.
// Optional feature macro: MULT_PIPE_SAT_EN
//   defined     : out-of-range results clamp to the OUT_W limit, overflow=1.
//   not defined : product is the low OUT_W bits of the shifted result,
//                 overflow is tied 0 and no fit-check logic exists.
// Ports:
//   p         in  FULL_W  full product (two's complement when is_signed)
//   is_signed in  1       interpretation of p
//   product   out OUT_W   scaled result
//   overflow  out 1       scaled result did not fit OUT_W
// ----------------------------------------------------------------------------
module mult_round_sat
    import mult_pkg::*;
#(
    parameter int FULL_W = 16,
    parameter int SHIFT  = 0,
    parameter int OUT_W  = 16
) (
    input  logic [FULL_W-1:0] p,
    input  logic              is_signed,
    output logic [OUT_W-1:0]  product,
    output logic              overflow
);

    localparam int EXT_W = FULL_W + 1;

    // One guard bit keeps the rounding add from wrapping in either mode.
    logic [FULL_W:0] p_ext;
    logic [FULL_W:0] r;

    assign p_ext = {is_signed & p[FULL_W-1], p};

    if (SHIFT > 0) begin : g_rnd
        localparam logic [FULL_W:0] HALF = EXT_W'(1) << (SHIFT - 1);
        logic        [FULL_W:0] sum;
        logic signed [FULL_W:0] r_s;

        assign sum = p_ext + HALF;
        // Kept as a separate signed net so >>> stays arithmetic; mixing it
        // into the unsigned mux would silently make it logical.
        assign r_s = $signed(sum) >>> SHIFT;
        assign r   = is_signed ? r_s : (sum >> SHIFT);
    end else begin : g_nornd
        assign r = p_ext;
    end

`ifdef MULT_PIPE_SAT_EN
    localparam logic [LIM_W-1:0] SMAX_L = sat_smax(OUT_W);
    localparam logic [LIM_W-1:0] SMIN_L = sat_smin(OUT_W);
    localparam logic [LIM_W-1:0] UMAX_L = sat_umax(OUT_W);
    localparam logic signed [FULL_W:0] S_MAX = SMAX_L[FULL_W:0];
    localparam logic signed [FULL_W:0] S_MIN = SMIN_L[FULL_W:0];
    localparam logic        [FULL_W:0] U_MAX = UMAX_L[FULL_W:0];

    logic fit_s;
    logic fit_u;

    assign fit_s = ($signed(r) <= S_MAX) && ($signed(r) >= S_MIN);
    assign fit_u = (r <= U_MAX);

    always_comb begin
        overflow = is_signed ? !fit_s : !fit_u;
        product  = r[OUT_W-1:0];
        if (overflow) begin
            if (is_signed) begin
                product = r[FULL_W] ? S_MIN[OUT_W-1:0] : S_MAX[OUT_W-1:0];
            end else begin
                product = U_MAX[OUT_W-1:0];
            end
        end
    end
`else
    logic unused_hi;

    assign unused_hi = ^r[FULL_W:OUT_W];
    assign product   = r[OUT_W-1:0];
    assign overflow  = 1'b0;
`endif

endmodule

// File: rtl/mult_pipe.sv
// ----------------------------------------------------------------------------
// mult_pipe
// Pipelined A_W x B_W multiplier with valid/ready flow control, per-beat
// signed/unsigned mode, round-half-up right shift and optional saturation.
// Optional feature macro: MULT_PIPE_SAT_EN (see mult_round_sat).
// Latency is PIPE cycles counting the accept cycle; lock-step pipeline, one
// global enable, bubbles are not compressed.
// Ports:
//   clk        in  1      clock, rising edge
//   rst        in  1      asynchronous active-high reset
//   in_valid   in  1      operand beat valid
//   in_ready   out 1      beat can be accepted this cycle
//   a          in  A_W    operand a
//   b          in  B_W    operand b
//   is_signed  in  1      1: two's complement operands, 0: unsigned
//   out_valid  out 1      product valid
//   out_ready  in  1      downstream accepts product
//   product    out OUT_W  scaled result (held between beats)
//   overflow   out 1      scaled result did not fit OUT_W
// ----------------------------------------------------------------------------
module mult_pipe
    import mult_pkg::*;
#(
    parameter int A_W   = 8,
    parameter int B_W   = 8,
    parameter int OUT_W = 16,
    parameter int SHIFT = 0,
    parameter int PIPE  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   a,
    input  logic [B_W-1:0]   b,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] product,
    output logic             overflow
);

    localparam int FULL_W = full_w(A_W, B_W);
    localparam int N_DLY  = PIPE - 3;

    logic en;

    logic              v1, s1;
    logic [A_W-1:0]    a_q;
    logic [B_W-1:0]    b_q;

    logic              v2, s2;
    logic [FULL_W-1:0] p2;

    logic [FULL_W-1:0] a_ext, b_ext, mul;

    logic              d_v, d_s;
    logic [FULL_W-1:0] d_p;

    logic [OUT_W-1:0]  rs_product;
    logic              rs_overflow;

    // Whole pipeline advances together; it only stalls when the output
    // register holds a beat that downstream is refusing.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1  <= 1'b0;
            s1  <= 1'b0;
            a_q <= '0;
            b_q <= '0;
        end else if (en) begin
            v1 <= in_valid;
            if (in_valid) begin
                a_q <= a;
                b_q <= b;
                s1  <= is_signed;
            end
        end
    end

    // Sign- or zero-extend both operands to the full width; the low FULL_W
    // bits of that product are correct for either mode, so one multiplier
    // serves both.
    assign a_ext = {{B_W{s1 & a_q[A_W-1]}}, a_q};
    assign b_ext = {{A_W{s1 & b_q[B_W-1]}}, b_q};
    assign mul   = a_ext * b_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2 <= 1'b0;
            s2 <= 1'b0;
            p2 <= '0;
        end else if (en) begin
            v2 <= v1;
            if (v1) begin
                p2 <= mul;
                s2 <= s1;
            end
        end
    end

    if (N_DLY == 0) begin : g_nodly
        assign d_v = v2;
        assign d_s = s2;
        assign d_p = p2;
    end else begin : g_dly
        logic [FULL_W-1:0] dp [N_DLY];
        logic              ds [N_DLY];
        logic              dv [N_DLY];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < N_DLY; i++) begin
                    dp[i] <= '0;
                    ds[i] <= 1'b0;
                    dv[i] <= 1'b0;
                end
            end else if (en) begin
                dv[0] <= v2;
                if (v2) begin
                    dp[0] <= p2;
                    ds[0] <= s2;
                end
                for (int i = 1; i < N_DLY; i++) begin
                    dv[i] <= dv[i-1];
                    if (dv[i-1]) begin
                        dp[i] <= dp[i-1];
                        ds[i] <= ds[i-1];
                    end
                end
            end
        end

        assign d_v = dv[N_DLY-1];
        assign d_s = ds[N_DLY-1];
        assign d_p = dp[N_DLY-1];
    end

    mult_round_sat #(
        .FULL_W (FULL_W),
        .SHIFT  (SHIFT),
        .OUT_W  (OUT_W)
    ) u_round_sat (
        .p         (d_p),
        .is_signed (d_s),
        .product   (rs_product),
        .overflow  (rs_overflow)
    );

    // product/overflow only load with a valid beat so they hold between beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            product   <= '0;
            overflow  <= 1'b0;
        end else if (en) begin
            out_valid <= d_v;
            if (d_v) begin
                product  <= rs_product;
                overflow <= rs_overflow;
            end
        end
    end

endmodule

// File: tb/tb_mult_pipe.sv
// ----------------------------------------------------------------------------
// tb_mult_pipe
// Three mult_pipe instances:
//   d0: defaults (8x8 -> 16, SHIFT=0, PIPE=3)
//   d1: OUT_W=8, SHIFT=4, PIPE=4
//   d2: OUT_W=8, SHIFT=0, PIPE=5
// Stimulus pushes hand-computed expectations into a per-instance queue; a
// monitor per instance pops and compares whenever a product is transferred.
// ----------------------------------------------------------------------------
module tb_mult_pipe;

`ifdef MULT_PIPE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    localparam int PIPE_OF [3] = '{3, 4, 5};

    typedef struct {
        logic [15:0] p;
        logic        ov;
        int          acc;
        bit          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv   [3];
    logic [7:0]  ia   [3];
    logic [7:0]  ib   [3];
    logic        isg  [3];
    logic        ordy [3];
    logic        irdy [3];
    logic        ov_v [3];
    logic        ovf  [3];
    logic [15:0] p0;
    logic [7:0]  p1, p2;
    logic [15:0] prod [3];

    exp_t sb [3][$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        prod[0] = p0;
        prod[1] = {8'h00, p1};
        prod[2] = {8'h00, p2};
    end

    mult_pipe #(.A_W(8), .B_W(8), .OUT_W(16), .SHIFT(0), .PIPE(3)) d0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]),
        .a(ia[0]), .b(ib[0]), .is_signed(isg[0]), .out_valid(ov_v[0]),
        .out_ready(ordy[0]), .product(p0), .overflow(ovf[0]));

    mult_pipe #(.A_W(8), .B_W(8), .OUT_W(8), .SHIFT(4), .PIPE(4)) d1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]),
        .a(ia[1]), .b(ib[1]), .is_signed(isg[1]), .out_valid(ov_v[1]),
        .out_ready(ordy[1]), .product(p1), .overflow(ovf[1]));

    mult_pipe #(.A_W(8), .B_W(8), .OUT_W(8), .SHIFT(0), .PIPE(5)) d2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irdy[2]),
        .a(ia[2]), .b(ib[2]), .is_signed(isg[2]), .out_valid(ov_v[2]),
        .out_ready(ordy[2]), .product(p2), .overflow(ovf[2]));

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic send(input int d, input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic [15:0] ep, input logic eo,
                        input bit push, input bit lat);
        int k;
        exp_t e;
        @(negedge clk);
        iv[d]  = 1'b1;
        ia[d]  = a;
        ib[d]  = b;
        isg[d] = s;
        #1;
        k = 0;
        while (!irdy[d] && k < 100) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (!irdy[d]) begin
            total++;
            bad++;
            $display("FAIL send_timeout: dut%0d in_ready stuck low after %0d cycles", d, k);
        end else if (push) begin
            e.p   = ep;
            e.ov  = eo;
            e.acc = cyc + 1;
            e.lat = lat;
            sb[d].push_back(e);
        end
        @(posedge clk);
    endtask

    task automatic idle(input int d);
        @(negedge clk);
        iv[d] = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        if ((sb[0].size() + sb[1].size() + sb[2].size()) != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d beats never emerged, want 0",
                     sb[0].size() + sb[1].size() + sb[2].size());
        end
        repeat (3) @(negedge clk);
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_mon
        initial begin
            exp_t e;
            forever begin
                @(negedge clk);
                #2;
                if (ov_v[g] && ordy[g]) begin
                    if (sb[g].size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_out: dut%0d product %h with empty scoreboard, want no beat",
                                 g, prod[g]);
                    end else begin
                        e = sb[g].pop_front();
                        total++;
                        if (prod[g] !== e.p || ovf[g] !== e.ov) begin
                            bad++;
                            $display("FAIL result dut%0d: got product=%h overflow=%b want product=%h overflow=%b",
                                     g, prod[g], ovf[g], e.p, e.ov);
                        end
                        if (e.lat) begin
                            total++;
                            if (cyc != e.acc + PIPE_OF[g] - 1) begin
                                bad++;
                                $display("FAIL latency dut%0d: out at edge %0d want edge %0d",
                                         g, cyc, e.acc + PIPE_OF[g] - 1);
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            iv[i]   = 1'b0;
            ia[i]   = 8'h00;
            ib[i]   = 8'h00;
            isg[i]  = 1'b0;
            ordy[i] = 1'b1;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_out_valid%0d", i), {15'd0, ov_v[i]}, 16'd0);
            check($sformatf("rst_overflow%0d", i),  {15'd0, ovf[i]},  16'd0);
            check($sformatf("rst_product%0d", i),   prod[i],          16'd0);
            check($sformatf("rst_in_ready%0d", i),  {15'd0, irdy[i]}, 16'd1);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // d0: full-width product, no scaling, latency checked on every beat
        send(0, 8'd200, 8'd250, 1'b0, 16'd50000, 1'b0, 1, 1);
        send(0, 8'hF6,  8'h07,  1'b1, 16'hFFBA,  1'b0, 1, 1);
        send(0, 8'hF6,  8'h07,  1'b0, 16'd1722,  1'b0, 1, 1);
        send(0, 8'h80,  8'h80,  1'b1, 16'h4000,  1'b0, 1, 1);
        send(0, 8'hFF,  8'hFF,  1'b0, 16'hFE01,  1'b0, 1, 1);
        idle(0);

        // d1: OUT_W=8, SHIFT=4, round half up
        send(1, 8'd15,  8'd15, 1'b0, 16'h000E, 1'b0, 1, 1);
        send(1, 8'hE8,  8'h01, 1'b1, 16'h00FF, 1'b0, 1, 1);
        send(1, 8'h08,  8'h01, 1'b0, 16'h0001, 1'b0, 1, 1);
        send(1, 8'hF8,  8'h01, 1'b1, 16'h0000, 1'b0, 1, 1);
        send(1, 8'hFF,  8'hFF, 1'b0, SAT ? 16'h00FF : 16'h00E0, SAT, 1, 1);
        send(1, 8'h7F,  8'h7F, 1'b1, SAT ? 16'h007F : 16'h00F0, SAT, 1, 1);
        send(1, 8'h80,  8'h7F, 1'b1, SAT ? 16'h0080 : 16'h0008, SAT, 1, 1);
        idle(1);

        // d2: OUT_W=8, SHIFT=0, fit boundaries
        send(2, 8'd100, 8'd100, 1'b1, SAT ? 16'h007F : 16'h0010, SAT, 1, 1);
        send(2, 8'h9C,  8'd100, 1'b1, SAT ? 16'h0080 : 16'h00F0, SAT, 1, 1);
        send(2, 8'h0F,  8'h11,  1'b0, 16'h00FF, 1'b0, 1, 1);
        send(2, 8'h10,  8'h10,  1'b0, SAT ? 16'h00FF : 16'h0000, SAT, 1, 1);
        send(2, 8'h0F,  8'hF8,  1'b1, 16'h0088, 1'b0, 1, 1);
        send(2, 8'hF0,  8'h08,  1'b1, 16'h0080, 1'b0, 1, 1);
        send(2, 8'h7F,  8'h01,  1'b1, 16'h007F, 1'b0, 1, 1);
        send(2, 8'hF0,  8'hF8,  1'b1, SAT ? 16'h007F : 16'h0080, SAT, 1, 1);
        idle(2);
        drain();

        // d0: back-to-back stream with a 5-cycle stall at the first output
        fork
            begin
                for (int i = 1; i <= 6; i++) begin
                    send(0, 8'(i), 8'(i), 1'b0, 16'(i * i), 1'b0, 1, 0);
                end
                idle(0);
            end
            begin
                k = 0;
                @(negedge clk);
                while (!ov_v[0] && k < 50) begin
                    @(negedge clk);
                    k++;
                end
                if (!ov_v[0]) begin
                    total++;
                    bad++;
                    $display("FAIL stall_wait: out_valid never rose, want 1");
                end else begin
                    ordy[0] = 1'b0;
                    for (int j = 0; j < 5; j++) begin
                        #1;
                        check("stall_in_ready", {15'd0, irdy[0]}, 16'd0);
                        check("stall_hold",     p0,               16'd1);
                        @(negedge clk);
                    end
                    ordy[0] = 1'b1;
                end
            end
        join
        drain();

        // d0: reset with beats in flight discards them
        send(0, 8'd2, 8'd3, 1'b0, 16'd6,  1'b0, 0, 0);
        send(0, 8'd4, 8'd5, 1'b0, 16'd20, 1'b0, 0, 0);
        send(0, 8'd6, 8'd7, 1'b0, 16'd42, 1'b0, 0, 0);
        #1;
        rst   = 1'b1;
        iv[0] = 1'b0;
        #1;
        check("rst_mid_out_valid", {15'd0, ov_v[0]}, 16'd0);
        check("rst_mid_in_ready",  {15'd0, irdy[0]}, 16'd1);
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_product", p0, 16'd0);
        repeat (8) @(negedge clk);
        send(0, 8'd3, 8'd5, 1'b0, 16'd15, 1'b0, 1, 1);
        idle(0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_pipe.md
# mult_pipe

Parametrised, pipelined multiplier with valid/ready flow control, a per-operand signed/unsigned mode, and a rounding shift plus saturating output stage. It is the next generation of the team's fixed 8x8 registered multiplier. It sits in DSP datapaths (FIR taps, mixers, gain stages), where it is fed by sample streams and drives accumulators or downstream FIFOs. It handles generic operand widths, configurable latency, back-pressure and fixed-point scaling.

## Interface
- A_W, 8, operand a width (>=2)
- B_W, 8, operand b width (>=2)
- OUT_W, 16, product output width (1..A_W+B_W)
- SHIFT, 0, right shift applied to full product before output (0..A_W+B_W-1)
- PIPE, 3, total latency in cycles from accepted input to out_valid (>=3)
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat this cycle
- a  in  A_W  operand a
- b  in  B_W  operand b
- is_signed  in  1  1: a, b two's complement; 0: unsigned; sampled with the beat
- out_valid  out  1  product valid
- out_ready  in  1  downstream accepts product
- product  out  OUT_W  scaled result
- overflow  out  1  scaled result did not fit OUT_W (qualified by out_valid)

## Operation
- Beat accepted when in_valid && in_ready. is_signed travels with the beat through every stage.
- Stage 1: register a, b and is_signed. Stage 2: full product P of width A_W+B_W, signed or unsigned per the beat's mode. Stages 3..PIPE-1: pure delay. Stage PIPE: round/shift/saturate, registered onto product/overflow.
- Rounding: when SHIFT>0, R = (P + 2^(SHIFT-1)) >>> SHIFT (round half up). The shift is arithmetic in signed mode and logical in unsigned mode. The add is done at A_W+B_W+1 bits so it cannot wrap. When SHIFT=0, R = P.
- Fit check: R must fit OUT_W as signed (signed mode) or unsigned (unsigned mode). If it does not fit, overflow=1 and product is handled per Configuration.
- Per-stage valid bits. Global advance enable en = !out_valid || out_ready. When en=0 every stage holds, including valid bits.
- in_ready = en (combinational). Bubbles are not compressed; this is a simple lock-step pipeline.
- Ordering is preserved. No beat is lost or duplicated under any out_ready pattern.

## Timing
- Reset (async assert, sync release on clk): all valid bits 0, out_valid=0, product=0, overflow=0, all data registers 0. in_ready=1 during and after reset.
- Reset mid-operation: all in-flight beats are discarded; out_valid drops immediately on rst assertion.
- Latency: a beat accepted at edge n gives out_valid=1 after edge n+PIPE-1, i.e. PIPE cycles counting the accept cycle. Throughput is 1 beat/cycle while out_ready=1.
- Stall: out_valid=1 && out_ready=0 holds product/overflow stable and drives in_ready=0 in the same cycle.
- Simultaneous out_ready=1 and in_valid=1 with a full pipeline: output retires and input is accepted in the same edge.
- product/overflow are don't-care when out_valid=0 but are held, never cleared, between beats.

## Configuration
- MULT_PIPE_SAT_EN defined: on overflow, product clamps to the OUT_W limit. Signed mode: max 2^(OUT_W-1)-1 / min -2^(OUT_W-1). Unsigned mode: 2^OUT_W-1 (unsigned R is never negative). overflow reports the clamp.
- Not defined: product = low OUT_W bits of R (wrap). overflow is tied 0 and the fit-check logic is not built.

## Structure
- Package mult_pkg: the width function for the full product (A_W+B_W) and localparam helpers for the signed/unsigned saturation limits as functions of OUT_W.
- Sub-module mult_round_sat: combinational round/shift/fit/clamp on P and is_signed, parametrised by the full width, SHIFT and OUT_W. It is instantiated once before the final register stage.
- The pipeline, valid chain and handshake live in mult_pipe itself.

## Test plan
- Defaults, unsigned, a=200, b=250, out_ready=1 -> product=50000, overflow=0, out_valid exactly PIPE cycles after accept.
- Defaults, signed, a=8'hF6 (-10), b=8'h07 -> product=16'hFFBA (-70); then unsigned, same bits -> 246*7=1722.
- OUT_W=8, SHIFT=4, unsigned 15*15=225 -> product=14. Signed a=-24, b=1 -> -1. Exact half rounds up.
- OUT_W=8, SHIFT=0, signed 100*100 -> with SAT_EN: 127, overflow=1; signed -100*100 -> -128, overflow=1. Without SAT_EN: 100*100 -> 8'h10, overflow=0.
- Stream 6 back-to-back beats (1*1..6*6). Hold out_ready=0 for 5 cycles starting at the first out_valid -> in_ready=0 during the stall, product held at 1. Full sequence 1,4,9,16,25,36 is delivered in order with no loss.
- Assert rst mid-stream with 3 beats in flight -> out_valid=0 immediately. After release, no stale beats emerge; the next accepted beat appears after PIPE cycles.
